// File: rtl/bfly_r2_pipe.sv
// Pipelined radix-2 complex butterfly in single-precision float: z0 = y + w*x, z1 = y - w*x.
// Contains the fp helper package and the fpu_mul/fpu_add pipelined cores it is built from.

package bfly_fp_pkg;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (|v[22:0]);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && !(|v[22:0]);
    endfunction

    // Subnormals are treated as zero throughout (flush-to-zero cores).
    function automatic logic is_zero(input logic [31:0] v);
        return v[30:23] == 8'h00;
    endfunction

    function automatic logic [31:0] neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        prod;
        logic signed [10:0] e;
        logic [22:0]        frac;
        logic               g;
        logic               st;
        logic               rnd;
        logic [23:0]        mr;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) || is_inf(b)) return (is_zero(a) || is_zero(b)) ? QNAN : {s, 8'hFF, 23'd0};
        if (is_zero(a) || is_zero(b)) return {s, 31'd0};
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 11'sd1;
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        rnd = g & (st | frac[0]);
        mr  = {1'b0, frac} + {23'd0, rnd};
        if (mr[23]) e = e + 11'sd1;
        if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        big;
        logic [31:0]        sml;
        logic [7:0]         dexp;
        logic [26:0]        mb;
        logic [26:0]        ms;
        logic [26:0]        msh;
        logic [26:0]        mask;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic signed [10:0] e;
        logic               rnd;
        logic [23:0]        mr;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
        if (is_zero(a)) return b;
        if (is_zero(b)) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        dexp = big[30:23] - sml[30:23];
        mb   = {1'b1, big[22:0], 3'b000};
        ms   = {1'b1, sml[22:0], 3'b000};
        // Three extra low bits hold guard, round and a sticky OR of everything shifted out.
        if (dexp > 8'd26) begin
            msh = 27'd1;
        end else begin
            mask = (27'd1 << dexp) - 27'd1;
            msh  = (ms >> dexp) | {26'd0, |(ms & mask)};
        end
        e = $signed({3'b000, big[30:23]});
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, msh};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 11'sd1;
            end
        end else begin
            sum = {1'b0, mb - msh};
            if (sum == 28'd0) return 32'd0;
            lz  = lzc27(sum[26:0]);
            sum = sum << lz;
            e   = e - $signed({6'd0, lz});
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        mr  = {1'b0, sum[25:3]} + {23'd0, rnd};
        if (mr[23]) e = e + 11'sd1;
        if (e >= 11'sd255) return {big[31], 8'hFF, 23'd0};
        if (e <= 11'sd0) return {big[31], 31'd0};
        return {big[31], e[7:0], mr[22:0]};
    endfunction

    // Divide by two by exponent decrement; results that would go subnormal flush to signed zero.
    function automatic logic [31:0] halve(input logic [31:0] v);
        if (v[30:23] == 8'hFF) return v;
        if (v[30:24] != 7'd0) return {v[31], v[30:23] - 8'd1, v[22:0]};
        return {v[31], 31'd0};
    endfunction

endpackage

module fpu_mul #(
    parameter int LAT = 4
) (
    input  logic        clock,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    import bfly_fp_pkg::*;

    logic [31:0] pipe [LAT];

    always_ff @(posedge clock) begin
        pipe[0] <= fmul(a, b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign y = pipe[LAT-1];
endmodule

module fpu_add #(
    parameter int LAT = 2
) (
    input  logic        clock,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    import bfly_fp_pkg::*;

    logic [31:0] pipe [LAT];

    always_ff @(posedge clock) begin
        pipe[0] <= fadd(a, b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign y = pipe[LAT-1];
endmodule

module bfly_r2_pipe #(
    parameter int MUL_LAT = 4,
    parameter int ADD_LAT = 2,
    parameter int BITS    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        inverse,
    input  logic        scale,
    input  logic [31:0] re_w,
    input  logic [31:0] im_w,
    input  logic [31:0] re_x,
    input  logic [31:0] im_x,
    input  logic [31:0] re_y,
    input  logic [31:0] im_y,
    output logic        out_valid,
    output logic [31:0] re_z0,
    output logic [31:0] im_z0,
    output logic [31:0] re_z1,
    output logic [31:0] im_z1,
    output logic        nan_out,
    output logic        err_sticky
);
    import bfly_fp_pkg::*;

    localparam int VLEN = MUL_LAT + 2 * ADD_LAT;
    localparam int YLEN = MUL_LAT + ADD_LAT;

    if (BITS != 32) begin : g_bits_check
        $error("bfly_r2_pipe: only BITS=32 is supported");
    end

    logic [31:0] im_w_c;
    logic [31:0] prod_a;
    logic [31:0] prod_b;
    logic [31:0] prod_c;
    logic [31:0] prod_d;
    logic [31:0] re_p;
    logic [31:0] im_p;
    logic [31:0] re_y_dl [YLEN];
    logic [31:0] im_y_dl [YLEN];
    logic [31:0] re_sum0;
    logic [31:0] im_sum0;
    logic [31:0] re_sum1;
    logic [31:0] im_sum1;
    logic [VLEN-1:0] v_pipe;
    logic [VLEN-1:0] s_pipe;
    logic [31:0] re_z0_s;
    logic [31:0] im_z0_s;
    logic [31:0] re_z1_s;
    logic [31:0] im_z1_s;
    logic        nan_s;

    assign im_w_c = inverse ? neg(im_w) : im_w;

    fpu_mul #(.LAT(MUL_LAT)) u_mul_a (.clock(clock), .a(re_x), .b(re_w),   .y(prod_a));
    fpu_mul #(.LAT(MUL_LAT)) u_mul_b (.clock(clock), .a(im_x), .b(im_w_c), .y(prod_b));
    fpu_mul #(.LAT(MUL_LAT)) u_mul_c (.clock(clock), .a(re_x), .b(im_w_c), .y(prod_c));
    fpu_mul #(.LAT(MUL_LAT)) u_mul_d (.clock(clock), .a(im_x), .b(re_w),   .y(prod_d));

    fpu_add #(.LAT(ADD_LAT)) u_add_rp (.clock(clock), .a(prod_a), .b(neg(prod_b)), .y(re_p));
    fpu_add #(.LAT(ADD_LAT)) u_add_ip (.clock(clock), .a(prod_c), .b(prod_d),      .y(im_p));

    // Datapath-only delay line; stale contents are masked by the valid pipeline.
    always_ff @(posedge clock) begin
        re_y_dl[0] <= re_y;
        im_y_dl[0] <= im_y;
        for (int i = 1; i < YLEN; i++) begin
            re_y_dl[i] <= re_y_dl[i-1];
            im_y_dl[i] <= im_y_dl[i-1];
        end
    end

    fpu_add #(.LAT(ADD_LAT)) u_add_r0 (.clock(clock), .a(re_y_dl[YLEN-1]), .b(re_p),      .y(re_sum0));
    fpu_add #(.LAT(ADD_LAT)) u_add_i0 (.clock(clock), .a(im_y_dl[YLEN-1]), .b(im_p),      .y(im_sum0));
    fpu_add #(.LAT(ADD_LAT)) u_add_r1 (.clock(clock), .a(re_y_dl[YLEN-1]), .b(neg(re_p)), .y(re_sum1));
    fpu_add #(.LAT(ADD_LAT)) u_add_i1 (.clock(clock), .a(im_y_dl[YLEN-1]), .b(neg(im_p)), .y(im_sum1));

    always_ff @(posedge clock) begin
        if (reset) begin
            v_pipe <= '0;
            s_pipe <= '0;
        end else begin
            v_pipe <= {v_pipe[VLEN-2:0], in_valid};
            s_pipe <= {s_pipe[VLEN-2:0], scale};
        end
    end

    always_comb begin
        re_z0_s = s_pipe[VLEN-1] ? halve(re_sum0) : re_sum0;
        im_z0_s = s_pipe[VLEN-1] ? halve(im_sum0) : im_sum0;
        re_z1_s = s_pipe[VLEN-1] ? halve(re_sum1) : re_sum1;
        im_z1_s = s_pipe[VLEN-1] ? halve(im_sum1) : im_sum1;
        nan_s   = (re_z0_s[30:23] == 8'hFF) || (im_z0_s[30:23] == 8'hFF) ||
                  (re_z1_s[30:23] == 8'hFF) || (im_z1_s[30:23] == 8'hFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            re_z0      <= '0;
            im_z0      <= '0;
            re_z1      <= '0;
            im_z1      <= '0;
            nan_out    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_valid <= v_pipe[VLEN-1];
            if (v_pipe[VLEN-1]) begin
                re_z0      <= re_z0_s;
                im_z0      <= im_z0_s;
                re_z1      <= re_z1_s;
                im_z1      <= im_z1_s;
                nan_out    <= nan_s;
                err_sticky <= err_sticky | nan_s;
            end
        end
    end
endmodule
